emulib_dma_write_engine: RTL and testbench
==========================================

// Module: emulib_dma_write_engine
// PURPOSE
//  Write half of the checkpoint DMA. Consumes the address/count/data streams emitted by the scan-chain
//  controller during scan-out, issues AXI4 INCR write bursts on the dma_axi master, one burst in flight.
//  Bursts are split at MAX_BURST_LEN and at 4 KiB boundaries. Sits between the scan controller and the AXI interconnect.
// PARAMETERS
//  ADDR_WIDTH     32   AXI address width
//  DATA_WIDTH     64   data beat width (power of 2, >= 8)
//  COUNT_WIDTH    16   width of transfer length in beats
//  MAX_BURST_LEN  16   max beats per burst (1..256)
// PORTS
//  host_clk               in   1            sole clock
//  host_rst               in   1            synchronous, active-high reset
//  s_write_addr_valid/ready  in/out 1       start-address handshake
//  s_write_addr           in   ADDR_WIDTH   byte address (low log2(DATA_WIDTH/8) bits ignored)
//  s_write_count_valid/ready in/out 1       length handshake
//  s_write_count          in   COUNT_WIDTH  transfer length in beats
//  s_write_data_valid/ready  in/out 1       data stream handshake
//  s_write_data           in   DATA_WIDTH   data beat
//  dma_axi_aw*  out/in  AW channel (valid,ready,addr,len[7:0],size,burst,lock,cache,prot,qos,region)
//  dma_axi_w*   out/in  W channel (valid,ready,data,strb,last); dma_axi_b* B channel (valid,ready,bresp)
//  w_idle                 out  1            no command held, no burst in flight
//  w_err                  out  1            sticky write-response error (see CONFIGURATION)
// BEHAVIOUR
//  Reset: state IDLE; all *_valid, *_ready, dma_axi_bready low; w_idle=1; w_err=0; captured regs cleared.
//  Constant AXI fields: awsize=log2(DATA_WIDTH/8), awburst=INCR, lock/cache/prot/qos/region=0, wstrb all ones.
//  FSM: IDLE -> CMD -> AW -> W -> B -> (AW | IDLE).
//   IDLE: addr_ready=!addr_held, count_ready=!count_held; both captured in any order or same cycle.
//     When both held, next cycle CMD. w_idle=1 only if IDLE and neither held.
//   CMD: count==0 -> IDLE (no AXI traffic, holds cleared). Else compute len -> AW.
//   Burst beats = min(remaining, MAX_BURST_LEN, (4096-addr[11:0])/BYTES); awlen=beats-1, registered.
//   AW: awvalid=1 with awaddr/awlen stable until awready; then W.
//   W: pass-through, no buffering: wvalid=s_write_data_valid, s_write_data_ready=wready, wdata=s_write_data;
//     wlast on beat_cnt==beats-1; after last beat accepted -> B.
//   B: bready=1; on bvalid: addr+=beats*BYTES, remaining-=beats; remaining==0 -> IDLE else -> AW.
//  s_write_data_ready=0 outside W; data presented early stalls, never dropped.
//  AW precedes W for each burst (no W before AW handshake); exactly one outstanding burst.
//  Address arithmetic modulo 2^ADDR_WIDTH; remaining uses COUNT_WIDTH bits; max count 2^COUNT_WIDTH-1.
//  New addr/count not accepted until return to IDLE with holds cleared.
//  host_rst mid-transfer: next cycle IDLE, all valids low, in-flight burst abandoned (interconnect
//   must be reset together); w_err cleared.
// CONFIGURATION
//  `EMULIB_DMA_WR_BRESP_CHECK_EN defined: bresp!=OKAY sets w_err (sticky until reset); transfer still
//   completes all bursts. Undefined: bresp ignored, w_err tied 0.
// STRUCTURE
//  Shared package emulib_dma_pkg: AXI burst/resp encodings (INCR, OKAY), 4 KiB page constant, FSM state
//   encoding, beat-bytes helper function.
//  One sub-module: emulib_dma_burst_calc (combinational: addr, remaining -> beats, awlen).
// TESTING
//  addr=0x0, count=5, MAX=16, always-ready slave -> one burst awlen=4, 5 beats, wlast on 5th, w_idle back to 1.
//  addr=0xFE0, count=8, DATA_WIDTH=64 -> bursts awaddr=0xFE0 len=3, then 0x1000 len=3 (4K split).
//  count=40, MAX=16 -> bursts len 15,15,7 at 0x0,0x80,0x100; next AW only after B of previous.
//  count_valid before addr_valid; count=0 -> both accepted, no AW, returns IDLE within 3 cycles.
//  Random wready/awready/bvalid + data_valid gaps -> data order and beat count preserved, no W before AW.
//  With macro: bresp=SLVERR on burst 2 of 3 -> w_err=1 persists, all 3 bursts complete; reset mid-W -> IDLE, w_err=0.

Source files
------------

// File: rtl/emulib_dma_pkg.sv
// Shared constants for the checkpoint DMA engines: AXI encodings, the 4 KiB page, FSM encoding
// and beat-size helpers.
package emulib_dma_pkg;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;
    localparam int         PAGE_BYTES     = 4096;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_CMD  = 3'd1;
    localparam logic [2:0] ST_AW   = 3'd2;
    localparam logic [2:0] ST_W    = 3'd3;
    localparam logic [2:0] ST_B    = 3'd4;

    function automatic int beat_bytes(input int data_width);
        return data_width / 8;
    endfunction

    function automatic int beat_size(input int data_width);
        return $clog2(data_width / 8);
    endfunction

endpackage

// File: rtl/emulib_dma_burst_calc.sv
// Burst sizing: beats = min(remaining, MAX_BURST_LEN, beats left in the 4 KiB page), returned as awlen.
module emulib_dma_burst_calc
    import emulib_dma_pkg::*;
#(
    parameter int DATA_WIDTH    = 64,
    parameter int COUNT_WIDTH   = 16,
    parameter int MAX_BURST_LEN = 16
) (
    input  logic [11:0]            page_offset,
    input  logic [COUNT_WIDTH-1:0] remaining,
    output logic [7:0]             awlen
);

    localparam int SIZE = beat_size(DATA_WIDTH);

    logic [12:0] page_room;
    logic [12:0] page_beats;
    logic [8:0]  cap;
    logic [8:0]  beats;

    always_comb begin
        page_room  = 13'(PAGE_BYTES) - {1'b0, page_offset};
        page_beats = page_room >> SIZE;
        cap        = (page_beats > 13'(MAX_BURST_LEN)) ? 9'(MAX_BURST_LEN) : page_beats[8:0];
        beats      = (remaining < COUNT_WIDTH'(cap)) ? remaining[8:0] : cap;
        // remaining==0 never reaches AW, so the wrap of beats-1 there is harmless
        awlen      = 8'(beats - 9'd1);
    end

endmodule

// File: rtl/emulib_dma_write_engine.sv
// Checkpoint DMA write half: address/count/data streams in, AXI4 INCR write bursts out, one in flight.
// Define EMULIB_DMA_WR_BRESP_CHECK_EN to latch non-OKAY write responses into w_err.
module emulib_dma_write_engine
    import emulib_dma_pkg::*;
#(
    parameter int ADDR_WIDTH    = 32,
    parameter int DATA_WIDTH    = 64,
    parameter int COUNT_WIDTH   = 16,
    parameter int MAX_BURST_LEN = 16
) (
    input  logic                      host_clk,
    input  logic                      host_rst,

    input  logic                      s_write_addr_valid,
    output logic                      s_write_addr_ready,
    input  logic [ADDR_WIDTH-1:0]     s_write_addr,
    input  logic                      s_write_count_valid,
    output logic                      s_write_count_ready,
    input  logic [COUNT_WIDTH-1:0]    s_write_count,
    input  logic                      s_write_data_valid,
    output logic                      s_write_data_ready,
    input  logic [DATA_WIDTH-1:0]     s_write_data,

    output logic                      dma_axi_awvalid,
    input  logic                      dma_axi_awready,
    output logic [ADDR_WIDTH-1:0]     dma_axi_awaddr,
    output logic [7:0]                dma_axi_awlen,
    output logic [2:0]                dma_axi_awsize,
    output logic [1:0]                dma_axi_awburst,
    output logic                      dma_axi_awlock,
    output logic [3:0]                dma_axi_awcache,
    output logic [2:0]                dma_axi_awprot,
    output logic [3:0]                dma_axi_awqos,
    output logic [3:0]                dma_axi_awregion,

    output logic                      dma_axi_wvalid,
    input  logic                      dma_axi_wready,
    output logic [DATA_WIDTH-1:0]     dma_axi_wdata,
    output logic [DATA_WIDTH/8-1:0]   dma_axi_wstrb,
    output logic                      dma_axi_wlast,

    input  logic                      dma_axi_bvalid,
    output logic                      dma_axi_bready,
    input  logic [1:0]                dma_axi_bresp,

    output logic                      w_idle,
    output logic                      w_err
);

    localparam int                    SIZE     = beat_size(DATA_WIDTH);
    localparam logic [ADDR_WIDTH-1:0] LSB_MASK = ADDR_WIDTH'((1 << SIZE) - 1);

    logic [2:0]             state;
    logic                   addr_held;
    logic                   count_held;
    logic [ADDR_WIDTH-1:0]  addr_reg;
    logic [COUNT_WIDTH-1:0] remaining;
    logic [7:0]             awlen_reg;
    logic [7:0]             beat_cnt;

    logic [8:0]             burst_beats;
    logic [ADDR_WIDTH-1:0]  next_addr;
    logic [COUNT_WIDTH-1:0] next_remaining;
    logic [11:0]            calc_offset;
    logic [COUNT_WIDTH-1:0] calc_remaining;
    logic [7:0]             calc_awlen;
    logic                   addr_fire;
    logic                   count_fire;
    logic                   w_fire;
    logic                   b_fire;

    assign burst_beats    = {1'b0, awlen_reg} + 9'd1;
    assign next_addr      = addr_reg + (ADDR_WIDTH'(burst_beats) << SIZE);
    assign next_remaining = remaining - COUNT_WIDTH'(burst_beats);

    // In B the next burst is sized from the post-increment address so AW can follow directly
    assign calc_offset    = (state == ST_B) ? next_addr[11:0] : addr_reg[11:0];
    assign calc_remaining = (state == ST_B) ? next_remaining : remaining;

    emulib_dma_burst_calc #(
        .DATA_WIDTH    (DATA_WIDTH),
        .COUNT_WIDTH   (COUNT_WIDTH),
        .MAX_BURST_LEN (MAX_BURST_LEN)
    ) u_burst_calc (
        .page_offset (calc_offset),
        .remaining   (calc_remaining),
        .awlen       (calc_awlen)
    );

    assign s_write_addr_ready  = !host_rst && (state == ST_IDLE) && !addr_held;
    assign s_write_count_ready = !host_rst && (state == ST_IDLE) && !count_held;
    assign addr_fire           = s_write_addr_valid && s_write_addr_ready;
    assign count_fire          = s_write_count_valid && s_write_count_ready;

    assign dma_axi_awvalid  = (state == ST_AW);
    assign dma_axi_awaddr   = addr_reg;
    assign dma_axi_awlen    = awlen_reg;
    assign dma_axi_awsize   = 3'(SIZE);
    assign dma_axi_awburst  = AXI_BURST_INCR;
    assign dma_axi_awlock   = 1'b0;
    assign dma_axi_awcache  = 4'd0;
    assign dma_axi_awprot   = 3'd0;
    assign dma_axi_awqos    = 4'd0;
    assign dma_axi_awregion = 4'd0;

    // W is a straight pass-through of the data stream while a burst is open
    assign dma_axi_wvalid     = (state == ST_W) && s_write_data_valid;
    assign s_write_data_ready = (state == ST_W) && dma_axi_wready;
    assign dma_axi_wdata      = s_write_data;
    assign dma_axi_wstrb      = '1;
    assign dma_axi_wlast      = (state == ST_W) && (beat_cnt == awlen_reg);
    assign w_fire             = dma_axi_wvalid && dma_axi_wready;

    assign dma_axi_bready = (state == ST_B);
    assign b_fire         = dma_axi_bvalid && dma_axi_bready;

    assign w_idle = (state == ST_IDLE) && !addr_held && !count_held;

    // NOTE: reset is synchronous here, so it lives inside the clocked block; all state uses <=.
    always_ff @(posedge host_clk) begin
        if (host_rst) begin
            state      <= ST_IDLE;
            addr_held  <= 1'b0;
            count_held <= 1'b0;
            addr_reg   <= '0;
            remaining  <= '0;
            awlen_reg  <= '0;
            beat_cnt   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (addr_fire) begin
                        addr_held <= 1'b1;
                        addr_reg  <= s_write_addr & ~LSB_MASK;
                    end
                    if (count_fire) begin
                        count_held <= 1'b1;
                        remaining  <= s_write_count;
                    end
                    if (addr_held && count_held) state <= ST_CMD;
                end
                ST_CMD: begin
                    if (remaining == '0) begin
                        state      <= ST_IDLE;
                        addr_held  <= 1'b0;
                        count_held <= 1'b0;
                    end else begin
                        awlen_reg <= calc_awlen;
                        state     <= ST_AW;
                    end
                end
                ST_AW: begin
                    beat_cnt <= '0;
                    if (dma_axi_awready) state <= ST_W;
                end
                ST_W: begin
                    if (w_fire) begin
                        beat_cnt <= beat_cnt + 8'd1;
                        if (dma_axi_wlast) state <= ST_B;
                    end
                end
                ST_B: begin
                    if (b_fire) begin
                        addr_reg  <= next_addr;
                        remaining <= next_remaining;
                        if (next_remaining == '0) begin
                            state      <= ST_IDLE;
                            addr_held  <= 1'b0;
                            count_held <= 1'b0;
                        end else begin
                            awlen_reg <= calc_awlen;
                            state     <= ST_AW;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef EMULIB_DMA_WR_BRESP_CHECK_EN
    always_ff @(posedge host_clk) begin
        if (host_rst) begin
            w_err <= 1'b0;
        end else if (b_fire && (dma_axi_bresp != AXI_RESP_OKAY)) begin
            w_err <= 1'b1;
        end
    end
`else
    logic [1:0] unused_bresp;
    assign unused_bresp = dma_axi_bresp;
    assign w_err        = 1'b0;
`endif

endmodule

// File: tb/tb_emulib_dma_write_engine.sv
// Scoreboard bench for emulib_dma_write_engine: directed transfers, AW/W expectations queued at issue
// time and compared by a monitor on every AW/W/B handshake.
module tb_emulib_dma_write_engine;

    logic        host_clk = 1'b0;
    logic        host_rst;
    logic        s_write_addr_valid, s_write_addr_ready;
    logic [31:0] s_write_addr;
    logic        s_write_count_valid, s_write_count_ready;
    logic [15:0] s_write_count;
    logic        s_write_data_valid, s_write_data_ready;
    logic [63:0] s_write_data;
    logic        awvalid, awready, awlock, wvalid, wready, wlast, bvalid, bready;
    logic [31:0] awaddr;
    logic [7:0]  awlen, wstrb;
    logic [2:0]  awsize, awprot;
    logic [1:0]  awburst, bresp;
    logic [3:0]  awcache, awqos, awregion;
    logic [63:0] wdata;
    logic        w_idle, w_err;

    always #5 host_clk = ~host_clk;

    emulib_dma_write_engine dut (
        .host_clk(host_clk), .host_rst(host_rst),
        .s_write_addr_valid(s_write_addr_valid), .s_write_addr_ready(s_write_addr_ready),
        .s_write_addr(s_write_addr),
        .s_write_count_valid(s_write_count_valid), .s_write_count_ready(s_write_count_ready),
        .s_write_count(s_write_count),
        .s_write_data_valid(s_write_data_valid), .s_write_data_ready(s_write_data_ready),
        .s_write_data(s_write_data),
        .dma_axi_awvalid(awvalid), .dma_axi_awready(awready), .dma_axi_awaddr(awaddr),
        .dma_axi_awlen(awlen), .dma_axi_awsize(awsize), .dma_axi_awburst(awburst),
        .dma_axi_awlock(awlock), .dma_axi_awcache(awcache), .dma_axi_awprot(awprot),
        .dma_axi_awqos(awqos), .dma_axi_awregion(awregion),
        .dma_axi_wvalid(wvalid), .dma_axi_wready(wready), .dma_axi_wdata(wdata),
        .dma_axi_wstrb(wstrb), .dma_axi_wlast(wlast),
        .dma_axi_bvalid(bvalid), .dma_axi_bready(bready), .dma_axi_bresp(bresp),
        .w_idle(w_idle), .w_err(w_err)
    );

    typedef struct packed { logic [31:0] addr; logic [7:0] len; } aw_t;
    typedef struct packed { logic [63:0] data; logic last; } w_t;

    aw_t         exp_aw[$];
    w_t          exp_w[$];
    logic [63:0] data_q[$];
    logic [1:0]  bresp_q[$];
    int          total = 0;
    int          bad   = 0;
    int          aw_out = 0;
    int          w_beats = 0;
    int          seq = 0;
    bit          rand_mode = 1'b0;
    bit          flush = 1'b0;
    aw_t         mon_aw;
    w_t          mon_w;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h want=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every handshake on the master side is matched against the scoreboard
    always @(negedge host_clk) begin
        if (host_rst || flush) begin
            aw_out = 0;
        end else begin
            if (awvalid && awready) begin
                check("aw_single_outstanding", 64'(aw_out), 64'd0);
                if (exp_aw.size() == 0) begin
                    check("aw_unexpected", 64'd1, 64'd0);
                end else begin
                    mon_aw = exp_aw.pop_front();
                    check("awaddr", 64'(awaddr), 64'(mon_aw.addr));
                    check("awlen", 64'(awlen), 64'(mon_aw.len));
                end
                check("aw_const_fields",
                      64'({awsize, awburst, awlock, awcache, awprot, awqos, awregion}),
                      64'({3'd3, 2'b01, 1'b0, 4'd0, 3'd0, 4'd0, 4'd0}));
                aw_out = 1;
            end
            if (wvalid && wready) begin
                check("w_after_aw", 64'(aw_out), 64'd1);
                if (exp_w.size() == 0) begin
                    check("w_unexpected", 64'd1, 64'd0);
                end else begin
                    mon_w = exp_w.pop_front();
                    check("wdata", wdata, mon_w.data);
                    check("wlast", 64'(wlast), 64'(mon_w.last));
                end
                check("wstrb", 64'(wstrb), 64'hFF);
                w_beats++;
            end
            if (bvalid && bready) begin
                check("b_matches_aw", 64'(aw_out), 64'd1);
                aw_out = 0;
            end
        end
    end

    // AXI slave: ready/valid patterns, B returned after each last beat
    initial begin
        bit w_f, last_f, b_f;
        int b_pend;
        b_pend  = 0;
        awready = 1'b0;
        wready  = 1'b0;
        bvalid  = 1'b0;
        bresp   = 2'b00;
        forever begin
            @(negedge host_clk);
            w_f    = wvalid && wready;
            last_f = wlast;
            b_f    = bvalid && bready;
            @(posedge host_clk);
            #1;
            if (flush) begin
                b_pend  = 0;
                bvalid  = 1'b0;
                awready = 1'b0;
                wready  = 1'b0;
            end else begin
                if (w_f && last_f) b_pend++;
                if (b_f) bvalid = 1'b0;
                if (!bvalid && b_pend > 0 && (!rand_mode || $urandom_range(0, 2) == 0)) begin
                    bvalid = 1'b1;
                    bresp  = (bresp_q.size() > 0) ? bresp_q.pop_front() : 2'b00;
                    b_pend--;
                end
                awready = rand_mode ? ($urandom_range(0, 2) != 0) : 1'b1;
                wready  = rand_mode ? ($urandom_range(0, 1) != 0) : 1'b1;
            end
        end
    end

    // Data source: holds each beat until accepted, optional gaps
    initial begin
        bit f;
        s_write_data_valid = 1'b0;
        s_write_data       = '0;
        forever begin
            @(negedge host_clk);
            f = s_write_data_valid && s_write_data_ready;
            @(posedge host_clk);
            #1;
            if (flush) begin
                data_q.delete();
                s_write_data_valid = 1'b0;
            end else begin
                if (f && data_q.size() > 0) void'(data_q.pop_front());
                if (f || !s_write_data_valid) begin
                    if (data_q.size() > 0 && (!rand_mode || $urandom_range(0, 3) != 0)) begin
                        s_write_data_valid = 1'b1;
                        s_write_data       = data_q[0];
                    end else begin
                        s_write_data_valid = 1'b0;
                    end
                end
            end
        end
    end

    task automatic expect_burst(input logic [31:0] a, input logic [7:0] len);
        aw_t e;
        w_t  b;
        e.addr = a;
        e.len  = len;
        exp_aw.push_back(e);
        for (int i = 0; i <= int'(len); i++) begin
            b.data = {16'hC0DE, 16'(seq), ~32'(seq)};
            b.last = (i == int'(len));
            exp_w.push_back(b);
            data_q.push_back(b.data);
            seq++;
        end
    endtask

    task automatic issue(input logic [31:0] a, input logic [15:0] c, input bit count_first);
        bit a_done, c_done, af, cf;
        int n;
        a_done = 1'b0;
        c_done = 1'b0;
        n      = 0;
        @(posedge host_clk);
        #1;
        s_write_addr        = a;
        s_write_count       = c;
        s_write_count_valid = 1'b1;
        s_write_addr_valid  = !count_first;
        while (!(a_done && c_done) && n < 200) begin
            @(negedge host_clk);
            af = s_write_addr_valid && s_write_addr_ready;
            cf = s_write_count_valid && s_write_count_ready;
            @(posedge host_clk);
            #1;
            n++;
            if (af) begin
                a_done = 1'b1;
                s_write_addr_valid = 1'b0;
            end
            if (cf) begin
                c_done = 1'b1;
                s_write_count_valid = 1'b0;
                if (count_first) s_write_addr_valid = 1'b1;
            end
        end
        check("cmd_handshake", 64'(a_done && c_done), 64'd1);
        s_write_addr_valid  = 1'b0;
        s_write_count_valid = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int n;
        n = 0;
        while (n < 3000 && !(exp_aw.size() == 0 && exp_w.size() == 0 && aw_out == 0 && w_idle === 1'b1)) begin
            @(negedge host_clk);
            n++;
        end
        check(name, 64'(n < 3000), 64'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        bad++;
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int w0;
        host_rst            = 1'b1;
        s_write_addr_valid  = 1'b0;
        s_write_count_valid = 1'b0;
        s_write_addr        = '0;
        s_write_count       = '0;
        repeat (3) @(posedge host_clk);
        @(negedge host_clk);
        check("rst_addr_ready", 64'(s_write_addr_ready), 64'd0);
        check("rst_count_ready", 64'(s_write_count_ready), 64'd0);
        check("rst_data_ready", 64'(s_write_data_ready), 64'd0);
        check("rst_awvalid", 64'(awvalid), 64'd0);
        check("rst_wvalid", 64'(wvalid), 64'd0);
        check("rst_bready", 64'(bready), 64'd0);
        check("rst_w_idle", 64'(w_idle), 64'd1);
        check("rst_w_err", 64'(w_err), 64'd0);
        @(posedge host_clk);
        #1;
        host_rst = 1'b0;
        @(negedge host_clk);
        check("idle_addr_ready", 64'(s_write_addr_ready), 64'd1);

        // Single short burst, data presented before the command
        expect_burst(32'h0, 8'd4);
        issue(32'h0, 16'd5, 1'b0);
        wait_done("t1_done");

        // 4 KiB page split
        expect_burst(32'hFE0, 8'd3);
        expect_burst(32'h1000, 8'd3);
        issue(32'hFE0, 16'd8, 1'b0);
        wait_done("t2_done");

        // MAX_BURST_LEN split
        expect_burst(32'h0, 8'd15);
        expect_burst(32'h80, 8'd15);
        expect_burst(32'h100, 8'd7);
        issue(32'h0, 16'd40, 1'b0);
        wait_done("t3_done");

        // Count before address, zero length: no AXI traffic, quick return to idle
        issue(32'h40, 16'd0, 1'b1);
        n = 0;
        while (w_idle !== 1'b1 && n < 10) begin
            @(negedge host_clk);
            n++;
        end
        check("t4_idle_within_3", 64'(n <= 3), 64'd1);
        repeat (5) @(negedge host_clk);
        check("t4_no_aw", 64'(aw_out), 64'd0);

        // Random backpressure on every channel plus data gaps, page and length splits combined
        rand_mode = 1'b1;
        expect_burst(32'hF00, 8'd15);
        expect_burst(32'hF80, 8'd15);
        expect_burst(32'h1000, 8'd15);
        expect_burst(32'h1080, 8'd1);
        issue(32'hF00, 16'd50, 1'b0);
        wait_done("t5_done");
        rand_mode = 1'b0;

        // Error response on the middle burst of three
        bresp_q.push_back(2'b00);
        bresp_q.push_back(2'b10);
        bresp_q.push_back(2'b00);
        expect_burst(32'h2000, 8'd15);
        expect_burst(32'h2080, 8'd15);
        expect_burst(32'h2100, 8'd7);
        issue(32'h2000, 16'd40, 1'b0);
        wait_done("t6_done");
`ifdef EMULIB_DMA_WR_BRESP_CHECK_EN
        check("t6_w_err_sticky", 64'(w_err), 64'd1);
`else
        check("t6_w_err_tied", 64'(w_err), 64'd0);
`endif

        // Reset in the middle of a W burst
        w0 = w_beats;
        expect_burst(32'h0, 8'd15);
        expect_burst(32'h80, 8'd3);
        issue(32'h0, 16'd20, 1'b0);
        n = 0;
        while (w_beats < w0 + 3 && n < 200) begin
            @(negedge host_clk);
            n++;
        end
        check("t7_reached_w", 64'(w_beats >= w0 + 3), 64'd1);
        @(posedge host_clk);
        #2;
        host_rst = 1'b1;
        flush    = 1'b1;
        exp_aw.delete();
        exp_w.delete();
        bresp_q.delete();
        repeat (3) @(posedge host_clk);
        @(negedge host_clk);
        check("t7_rst_awvalid", 64'(awvalid), 64'd0);
        check("t7_rst_wvalid", 64'(wvalid), 64'd0);
        check("t7_rst_w_idle", 64'(w_idle), 64'd1);
        check("t7_rst_w_err", 64'(w_err), 64'd0);
        @(posedge host_clk);
        #2;
        host_rst = 1'b0;
        flush    = 1'b0;
        @(negedge host_clk);
        check("t7_post_w_idle", 64'(w_idle), 64'd1);

        // Recovery transfer after the abandoned one
        expect_burst(32'h200, 8'd2);
        issue(32'h200, 16'd3, 1'b0);
        wait_done("t8_done");
        check("t8_w_err", 64'(w_err), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
